jt7759_cendiv: RTL and testbench

Parametrised clock-enable generator for the JT7759 ADPCM core and its derivatives. It derives the decoder sample-rate enable and the control-logic enable from the 640 kHz master enable, using a programmable divider. Compared with the fixed 6-bit divider it adds:
- configurable width and sub-count;
- a configurable minimum divider;
- a selectable control-enable mode;
- a synchronous phase-restart input.

It sits between the chip-level clock-enable source and the control FSM / ADPCM decoder.

---
 rtl/jt7759_cendiv.sv | 72 +++++++
 tb/tb_jt7759_cendiv.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/jt7759_cendiv.sv
// Clock-enable divider for the JT7759 ADPCM core: derives the decoder step enable
// and the control-logic enable from the 640 kHz master enable.
module jt7759_cendiv #(
  parameter int DW       = 6,
  parameter int SUBW     = 2,
  parameter int DIVMIN   = 9,
  parameter int CTL_MODE = 0
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          cen,
  input  logic [DW-1:0] divby,
  input  logic          sync,
  output logic          cen_ctl,
  output logic          cen_dec,
  output logic [DW-1:0] divby_l
);

  localparam logic [DW-1:0] DIVMIN_L = DW'(DIVMIN);

  logic [SUBW-1:0] sub;
  logic [DW-1:0]   dec;
  logic [DW-1:0]   ctl;

  logic          eoc_sub;
  logic          eoc_dec;
  logic          eoc_ctl;
  logic          eop;
  logic [DW-1:0] div_next;

  function automatic logic [DW-1:0] clamp(input logic [DW-1:0] x);
    return (x < DIVMIN_L) ? DIVMIN_L : x;
  endfunction

  always_comb begin
    eoc_sub  = &sub;
    eoc_dec  = (dec == divby_l);
    eoc_ctl  = (ctl == (divby_l >> 1));
    eop      = eoc_sub & eoc_dec;
    div_next = clamp(divby);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub     <= '0;
      dec     <= '0;
      ctl     <= '0;
      divby_l <= DIVMIN_L;
      cen_ctl <= 1'b0;
      cen_dec <= 1'b0;
    end else if (sync) begin
      // Phase restart wins over a coincident cen tick, which is dropped.
      sub     <= '0;
      dec     <= '0;
      ctl     <= '0;
      divby_l <= div_next;
      cen_ctl <= 1'b0;
      cen_dec <= 1'b0;
    end else begin
      cen_dec <= cen & eop;
      // The period end also closes the (possibly short) last control segment.
      cen_ctl <= (CTL_MODE != 0) ? (cen & (eoc_ctl | eop)) : cen;
      if (cen) begin
        sub <= sub + SUBW'(1);
        if (eoc_sub) dec <= eoc_dec ? '0 : dec + DW'(1);
        if (eop) divby_l <= div_next;
        ctl <= (eoc_ctl | eop) ? '0 : ctl + DW'(1);
      end
    end
  end

endmodule

// File: tb/tb_jt7759_cendiv.sv
// Bench for jt7759_cendiv: a CTL_MODE=0 and a CTL_MODE=1 instance, directed vectors,
// expected pulse cycles queued by the drivers and checked by a negedge monitor.
module tb_jt7759_cendiv;

  localparam int DW = 6;

  typedef struct {
    int ch;
    int cyc;
  } exp_t;

  // Channels: 0 = dec0, 1 = ctl0, 2 = dec1, 3 = ctl1
  exp_t exp_q[$];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cen0 = 1'b0, sync0 = 1'b0;
  logic          cen1 = 1'b0, sync1 = 1'b0;
  logic [DW-1:0] divby0 = 6'd9, divby1 = 6'd9;
  logic          cen_ctl0, cen_dec0, cen_ctl1, cen_dec1;
  logic [DW-1:0] divby_l0, divby_l1;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  jt7759_cendiv dut0 (
    .rst(rst), .clk(clk), .cen(cen0), .divby(divby0), .sync(sync0),
    .cen_ctl(cen_ctl0), .cen_dec(cen_dec0), .divby_l(divby_l0)
  );

  jt7759_cendiv #(.CTL_MODE(1)) dut1 (
    .rst(rst), .clk(clk), .cen(cen1), .divby(divby1), .sync(sync1),
    .cen_ctl(cen_ctl1), .cen_dec(cen_dec1), .divby_l(divby_l1)
  );

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d cyc=%0d", name, got, want, cyc);
    end
  endtask

  task automatic push(input int ch, input int rel);
    exp_t e;
    e.ch  = ch;
    e.cyc = cyc + rel;
    exp_q.push_back(e);
  endtask

  // Drivers: entered and left at posedge+1; an input applied here is sampled on
  // the next posedge and its response is visible at cyc+1.
  task automatic step0(input logic c, input logic s);
    cen0  = c;
    sync0 = s;
    if (c && !s) push(1, 1);
    @(posedge clk); #1;
    cen0  = 1'b0;
    sync0 = 1'b0;
  endtask

  task automatic step1(input logic c, input logic s);
    cen1  = c;
    sync1 = s;
    @(posedge clk); #1;
    cen1  = 1'b0;
    sync1 = 1'b0;
  endtask

  // Scoreboard monitor
  logic [3:0] got_v, want_v;
  always @(negedge clk) begin
    if (mon_en) begin
      got_v  = {cen_ctl1, cen_dec1, cen_ctl0, cen_dec0};
      want_v = '0;
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].cyc == cyc) begin
          want_v[exp_q[i].ch] = 1'b1;
          exp_q.delete(i);
        end else if (exp_q[i].cyc < cyc) begin
          check("stale_expectation", exp_q[i].cyc, cyc);
          exp_q.delete(i);
        end
      end
      check("pulse_dec0", int'(got_v[0]), int'(want_v[0]));
      check("pulse_ctl0", int'(got_v[1]), int'(want_v[1]));
      check("pulse_dec1", int'(got_v[2]), int'(want_v[2]));
      check("pulse_ctl1", int'(got_v[3]), int'(want_v[3]));
    end
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cen_dec0", int'(cen_dec0), 0);
    check("rst_cen_ctl0", int'(cen_ctl0), 0);
    check("rst_divby_l0", int'(divby_l0), 9);
    check("rst_divby_l1", int'(divby_l1), 9);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Defaults, divby=9: 40-tick period, cen_ctl follows every cen
    divby0 = 6'd9;
    push(0, 40); push(0, 80); push(0, 120);
    repeat (120) step0(1'b1, 1'b0);
    check("t1_divby_l0", int'(divby_l0), 9);

    // divby=3 is clamped to DIVMIN
    divby0 = 6'd3;
    push(0, 40); push(0, 80);
    for (int j = 1; j <= 80; j++) begin
      step0(1'b1, 1'b0);
      check("t2_divby_l0", int'(divby_l0), 9);
    end

    // divby 9 -> 20 at tick 15: period ends at 40, next one is 84 ticks
    divby0 = 6'd9;
    push(0, 40); push(0, 124);
    repeat (14) step0(1'b1, 1'b0);
    divby0 = 6'd20;
    for (int j = 15; j <= 124; j++) begin
      step0(1'b1, 1'b0);
      if (j == 39) check("t3_divby_l0_before", int'(divby_l0), 9);
      if (j == 40) check("t3_divby_l0_at_eop", int'(divby_l0), 20);
    end

    // CTL_MODE=1, divby=12: ctl every 7 ticks, short last segment, dec at 52
    divby1 = 6'd12;
    step1(1'b0, 1'b1);
    check("t4_divby_l1", int'(divby_l1), 12);
    for (int p = 0; p < 2; p++) begin
      for (int k = 1; k <= 7; k++) push(3, p * 52 + k * 7);
      push(3, p * 52 + 52);
      push(2, p * 52 + 52);
    end
    repeat (104) step1(1'b1, 1'b0);

    // CTL_MODE=1, divby=all-ones: 256-tick period, ctl every 32 ticks
    divby1 = 6'd63;
    step1(1'b0, 1'b1);
    check("t7_divby_l1", int'(divby_l1), 63);
    for (int k = 1; k <= 8; k++) push(3, k * 32);
    push(2, 256);
    repeat (256) step1(1'b1, 1'b0);

    // sync with cen at tick 23: no pulse, reload, then 40 fresh ticks
    divby0 = 6'd9;
    repeat (22) step0(1'b1, 1'b0);
    step0(1'b1, 1'b1);
    check("t5_divby_l0", int'(divby_l0), 9);
    push(0, 40);
    repeat (40) step0(1'b1, 1'b0);

    // Async reset mid-period with cen every 3rd clk
    divby0 = 6'd20;
    step0(1'b0, 1'b1);
    check("t6_divby_l0_loaded", int'(divby_l0), 20);
    repeat (9) begin
      step0(1'b1, 1'b0); step0(1'b0, 1'b0); step0(1'b0, 1'b0);
    end
    step0(1'b1, 1'b0);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("t6_async_cen_ctl0", int'(cen_ctl0), 0);
    check("t6_async_cen_dec0", int'(cen_dec0), 0);
    check("t6_async_divby_l0", int'(divby_l0), 9);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    push(0, 118);
    repeat (40) begin
      step0(1'b1, 1'b0); step0(1'b0, 1'b0); step0(1'b0, 1'b0);
    end

    repeat (5) step0(1'b0, 1'b0);
    check("leftover_expectations", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
